dsp_frame_sequencer: RTL and testbench

Frame sequencer and configuration controller for the DSP subsystem's sample input. It sits between the free-running sample source and the DSP subsystem's AXI-Stream slave port, and cuts the continuous stream into frames of programmable length. Each frame is marked with `tuser` on its first beat and `tlast` on its last beat. Software controls it through an AHB-Lite register slave (single-shot or continuous framing, inter-frame gap, abort), and it raises an interrupt when a frame completes.

---
 rtl/dsp_frame_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_dsp_frame_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_frame_sequencer.sv
// Frame sequencer: slices a free-running sample stream into tuser/tlast-marked
// frames under AHB-Lite register control, with a frame-done interrupt.
module dsp_frame_sequencer #(
    parameter int unsigned DW            = 16,
    parameter int unsigned FRAME_LEN_RST = 1024
) (
    input  logic          hclk,
    input  logic          hresetn,
    input  logic          ce,
    input  logic [31:0]   haddr_s,
    input  logic [1:0]    htrans_s,
    input  logic          hwrite_s,
    input  logic [2:0]    hsize_s,
    input  logic [2:0]    hburst_s,
    input  logic [31:0]   hwdata_s,
    input  logic          hsel_s,
    output logic [31:0]   hrdata_s,
    output logic          hreadyout_s,
    output logic          hresp_s,
    input  logic [DW-1:0] tdata_s,
    input  logic          tvalid_s,
    output logic          tready_s,
    output logic [DW-1:0] tdata_m,
    output logic          tvalid_m,
    input  logic          tready_m,
    output logic          tlast_m,
    output logic          tuser_m,
    output logic          irq
);

    localparam int unsigned CW = 16;
    localparam logic [2:0] A_CTRL  = 3'd0;
    localparam logic [2:0] A_FLEN  = 3'd1;
    localparam logic [2:0] A_GAP   = 3'd2;
    localparam logic [2:0] A_STAT  = 3'd3;
    localparam logic [2:0] A_IRQEN = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            dp_valid_q, dp_write_q;
    logic [2:0]      dp_addr_q;
    logic            cont_q, done_q, irqen_q;
    logic [CW-1:0]   frame_len_q, gap_q, fcnt_q;
    logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [CW-1:0]   gap_cnt_q, gap_cnt_d;
    logic [CW-1:0]   flen_lat_q, flen_lat_d;
    logic            abort_pend_q, abort_pend_d;
    logic            wr, wr_ctrl, wr_flen, wr_gap, wr_stat, wr_irqen;
    logic            start_req, abort_req;
    logic            beat, last_beat, frame_done, fcnt_clr, busy;
    logic            unused_ok;

    assign hreadyout_s = 1'b1;
    assign hresp_s     = 1'b0;
    assign tdata_m     = tdata_s;
    assign busy        = (state_q != ST_IDLE);
    assign irq         = done_q & irqen_q;
    assign unused_ok   = ^{haddr_s[31:5], haddr_s[1:0], htrans_s[0], hsize_s, hburst_s, hwdata_s[31:16]};

    // Data-phase write strobes; ABORT in the same write suppresses START
    assign wr        = dp_valid_q & dp_write_q;
    assign wr_ctrl   = wr & (dp_addr_q == A_CTRL);
    assign wr_flen   = wr & (dp_addr_q == A_FLEN);
    assign wr_gap    = wr & (dp_addr_q == A_GAP);
    assign wr_stat   = wr & (dp_addr_q == A_STAT);
    assign wr_irqen  = wr & (dp_addr_q == A_IRQEN);
    assign abort_req = wr_ctrl & hwdata_s[2];
    assign start_req = wr_ctrl & hwdata_s[0] & ~hwdata_s[2];

    // Capture the AHB address phase
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_addr_q  <= '0;
        end else begin
            dp_valid_q <= hsel_s & htrans_s[1];
            dp_write_q <= hwrite_s;
            dp_addr_q  <= haddr_s[4:2];
        end
    end

    // Software-visible registers; DONE set beats a simultaneous clear
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            cont_q      <= 1'b0;
            frame_len_q <= CW'(FRAME_LEN_RST);
            gap_q       <= '0;
            irqen_q     <= 1'b0;
            done_q      <= 1'b0;
            fcnt_q      <= '0;
        end else begin
            if (wr_ctrl)  cont_q      <= hwdata_s[1];
            if (wr_flen)  frame_len_q <= (hwdata_s[15:0] == 16'd0) ? CW'(1) : hwdata_s[15:0];
            if (wr_gap)   gap_q       <= hwdata_s[15:0];
            if (wr_irqen) irqen_q     <= hwdata_s[0];
            if (frame_done)                  done_q <= 1'b1;
            else if (wr_stat && hwdata_s[1]) done_q <= 1'b0;
            if (fcnt_clr)        fcnt_q <= '0;
            else if (frame_done) fcnt_q <= fcnt_q + CW'(1);
        end
    end

    // Read mux reflects register contents before the data-phase edge
    always_comb begin
        hrdata_s = '0;
        if (dp_valid_q && !dp_write_q) begin
            case (dp_addr_q)
                A_CTRL:  hrdata_s = {30'd0, cont_q, 1'b0};
                A_FLEN:  hrdata_s = {16'd0, frame_len_q};
                A_GAP:   hrdata_s = {16'd0, gap_q};
                A_STAT:  hrdata_s = {fcnt_q, 14'd0, done_q, busy};
                A_IRQEN: hrdata_s = {31'd0, irqen_q};
                default: hrdata_s = '0;
            endcase
        end
    end

    // Framing state and counters
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q      <= ST_IDLE;
            beat_cnt_q   <= '0;
            gap_cnt_q    <= '0;
            flen_lat_q   <= CW'(1);
            abort_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            flen_lat_q   <= flen_lat_d;
            abort_pend_q <= abort_pend_d;
        end
    end

    // Next-state and stream handshake decode; ce=0 holds everything
    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        flen_lat_d   = flen_lat_q;
        abort_pend_d = abort_pend_q;
        frame_done   = 1'b0;
        fcnt_clr     = 1'b0;
        beat         = 1'b0;
        last_beat    = 1'b0;
        tready_s     = 1'b0;
        tvalid_m     = 1'b0;
        tlast_m      = 1'b0;
        tuser_m      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tready_s = ce;
                if (ce && start_req) begin
                    state_d    = ST_RUN;
                    beat_cnt_d = '0;
                    flen_lat_d = frame_len_q;
                    fcnt_clr   = 1'b1;
                end
            end
            ST_RUN: begin
                tvalid_m  = tvalid_s & ce;
                tready_s  = tready_m & ce;
                beat      = tvalid_s & tready_m & ce;
                tuser_m   = (beat_cnt_q == '0);
                last_beat = (beat_cnt_q == flen_lat_q - CW'(1));
                tlast_m   = last_beat | abort_pend_q;
                if (abort_req) abort_pend_d = 1'b1;
                if (beat) begin
                    if (abort_pend_q) begin
                        state_d = ST_IDLE;
                    end else if (last_beat) begin
                        frame_done = 1'b1;
                        beat_cnt_d = '0;
                        if (cont_q && !abort_req) begin
                            if (gap_q != '0) begin
                                state_d   = ST_GAP;
                                gap_cnt_d = gap_q;
                            end else begin
                                flen_lat_d = frame_len_q;
                            end
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + CW'(1);
                    end
                end
            end
            ST_GAP: begin
                tready_s = ce;
                if (ce) begin
                    if (!cont_q || abort_req) begin
                        state_d = ST_IDLE;
                    end else if (gap_cnt_q == CW'(1)) begin
                        state_d    = ST_RUN;
                        beat_cnt_d = '0;
                        flen_lat_d = frame_len_q;
                    end else begin
                        gap_cnt_d = gap_cnt_q - CW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d == ST_IDLE) abort_pend_d = 1'b0;
    end

endmodule

// File: tb/tb_dsp_frame_sequencer.sv
// Testbench for dsp_frame_sequencer: randomized register/stream scenarios
// checked against a frame-level reference model.
module tb_dsp_frame_sequencer;

    localparam int unsigned DW = 16;

    logic          hclk = 1'b0;
    logic          hresetn = 1'b0;
    logic          ce = 1'b1;
    logic [31:0]   haddr_s = '0;
    logic [1:0]    htrans_s = 2'b00;
    logic          hwrite_s = 1'b0;
    logic [2:0]    hsize_s = 3'b010;
    logic [2:0]    hburst_s = 3'b000;
    logic [31:0]   hwdata_s = '0;
    logic          hsel_s = 1'b0;
    logic [31:0]   hrdata_s;
    logic          hreadyout_s, hresp_s;
    logic [DW-1:0] tdata_s = '0;
    logic          tvalid_s = 1'b1;
    logic          tready_s;
    logic [DW-1:0] tdata_m;
    logic          tvalid_m;
    logic          tready_m = 1'b1;
    logic          tlast_m, tuser_m, irq;

    int            n_vec = 0;
    int            n_err = 0;
    logic          bp_mode = 1'b0;
    logic          trace_en = 1'b0;
    logic          src_take = 1'b0;
    logic [DW-1:0] bdata[$];
    logic          buser[$];
    logic          blast[$];
    logic          trace[$];

    dsp_frame_sequencer #(.DW(DW), .FRAME_LEN_RST(1024)) dut (
        .hclk(hclk), .hresetn(hresetn), .ce(ce),
        .haddr_s(haddr_s), .htrans_s(htrans_s), .hwrite_s(hwrite_s),
        .hsize_s(hsize_s), .hburst_s(hburst_s), .hwdata_s(hwdata_s), .hsel_s(hsel_s),
        .hrdata_s(hrdata_s), .hreadyout_s(hreadyout_s), .hresp_s(hresp_s),
        .tdata_s(tdata_s), .tvalid_s(tvalid_s), .tready_s(tready_s),
        .tdata_m(tdata_m), .tvalid_m(tvalid_m), .tready_m(tready_m),
        .tlast_m(tlast_m), .tuser_m(tuser_m), .irq(irq)
    );

    always #5 hclk = ~hclk;

    // Observe handshakes mid-cycle, where inputs and outputs are stable
    always @(negedge hclk) begin
        if (hresetn && tvalid_m && tready_m) begin
            bdata.push_back(tdata_m);
            buser.push_back(tuser_m);
            blast.push_back(tlast_m);
        end
        if (trace_en) trace.push_back(tvalid_m);
        src_take = tvalid_s && tready_s;
    end

    // Sample source advances only on its own handshake; sink may backpressure
    always @(posedge hclk) begin
        #1;
        if (src_take) tdata_s = tdata_s + 1'b1;
        tready_m = bp_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        tvalid_s = bp_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
        hsel_s = 1'b1; htrans_s = 2'b10; hwrite_s = 1'b1; haddr_s = a;
        @(posedge hclk); #1;
        hsel_s = 1'b0; htrans_s = 2'b00; hwrite_s = 1'b0; hwdata_s = d;
        @(posedge hclk); #1;
    endtask

    task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
        hsel_s = 1'b1; htrans_s = 2'b10; hwrite_s = 1'b0; haddr_s = a;
        @(posedge hclk); #1;
        hsel_s = 1'b0; htrans_s = 2'b00;
        @(negedge hclk);
        d = hrdata_s;
        @(posedge hclk); #1;
    endtask

    task automatic clear_log();
        bdata.delete(); buser.delete(); blast.delete(); trace.delete();
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic [31:0] offs [6] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14};
        logic [31:0] vals [6] = '{32'h0, 32'd1024, 32'h0, 32'h0, 32'h0, 32'h0};
        hresetn = 1'b0;
        repeat (3) @(posedge hclk);
        @(negedge hclk);
        n_vec++;
        if ({tvalid_m, tlast_m, tuser_m, irq} !== 4'b0000) begin
            n_err++; $display("FAIL reset_stream: got v/l/u/irq=%b want 0000", {tvalid_m, tlast_m, tuser_m, irq});
        end
        n_vec++;
        if (hrdata_s !== 32'd0 || hreadyout_s !== 1'b1 || hresp_s !== 1'b0) begin
            n_err++; $display("FAIL reset_ahb: got rdata=%h rdy=%b resp=%b want 0/1/0", hrdata_s, hreadyout_s, hresp_s);
        end
        n_vec++;
        if (tdata_m !== tdata_s) begin
            n_err++; $display("FAIL reset_tdata: got %h want %h", tdata_m, tdata_s);
        end
        @(posedge hclk); #1;
        hresetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ahb_read(offs[i], rd);
            n_vec++;
            if (rd !== vals[i]) begin
                n_err++; $display("FAIL reset_reg_%0h: got %h want %h", offs[i], rd, vals[i]);
            end
        end
    endtask

    task automatic test_regs();
        logic [31:0] rd, v;
        ahb_write(32'h04, 32'h0);
        ahb_read(32'h04, rd);
        n_vec++;
        if (rd !== 32'd1) begin n_err++; $display("FAIL flen_zero: got %h want 1", rd); end
        for (int i = 0; i < 3; i++) begin
            v = $urandom;
            ahb_write(32'h08, v);
            ahb_read(32'h08, rd);
            n_vec++;
            if (rd !== {16'd0, v[15:0]}) begin n_err++; $display("FAIL gap_rw: got %h want %h", rd, {16'd0, v[15:0]}); end
        end
        ahb_write(32'h18, 32'hFFFF_FFFF);
        ahb_read(32'h18, rd);
        n_vec++;
        if (rd !== 32'd0) begin n_err++; $display("FAIL unmapped: got %h want 0", rd); end
        ahb_write(32'h10, 32'hFFFF_FFFF);
        ahb_read(32'h10, rd);
        n_vec++;
        if (rd !== 32'd1) begin n_err++; $display("FAIL irqen_rw: got %h want 1", rd); end
        ahb_write(32'h00, 32'h2);
        ahb_read(32'h00, rd);
        n_vec++;
        if (rd !== 32'd2) begin n_err++; $display("FAIL ctrl_cont: got %h want 2", rd); end
        ahb_write(32'h00, 32'h0);
        ahb_write(32'h10, 32'h0);
    endtask

    task automatic test_single_shot(input int len);
        logic [31:0] rd;
        int bad;
        ahb_write(32'h04, 32'(len));
        clear_log();
        ahb_write(32'h00, 32'h1);
        repeat (len + 5) @(posedge hclk); #1;
        n_vec++;
        if (bdata.size() !== len) begin n_err++; $display("FAIL single_count_len%0d: got %0d want %0d", len, bdata.size(), len); end
        bad = 0;
        for (int i = 0; i < bdata.size(); i++)
            if (buser[i] !== (i == 0) || blast[i] !== (i == len - 1) || bdata[i] !== DW'(int'(bdata[0]) + i)) bad++;
        n_vec++;
        if (bad !== 0) begin n_err++; $display("FAIL single_shape_len%0d: got %0d bad beats want 0", len, bad); end
        ahb_read(32'h0C, rd);
        n_vec++;
        if (rd !== 32'h0001_0002) begin n_err++; $display("FAIL single_status_len%0d: got %h want 00010002", len, rd); end
    endtask

    task automatic test_continuous(input int len, input int gap);
        logic [31:0] rd;
        int period, bad, frames;
        period = len + gap;
        ahb_write(32'h04, 32'(len));
        ahb_write(32'h08, 32'(gap));
        clear_log();
        ahb_write(32'h00, 32'h3);
        trace_en = 1'b1;
        repeat (4 * period + $urandom_range(0, period - 1)) @(posedge hclk); #1;
        ahb_write(32'h00, 32'h0);
        repeat (period + 10) @(posedge hclk); #1;
        trace_en = 1'b0;
        bad = 0;
        if (trace.size() < 4 * period) bad = 1000;
        else for (int i = 0; i < 4 * period; i++) if (trace[i] !== ((i % period) < len)) bad++;
        n_vec++;
        if (bad !== 0) begin n_err++; $display("FAIL cont_gap_pattern_%0d_%0d: got %0d bad cycles want 0", len, gap, bad); end
        n_vec++;
        if (bdata.size() % len !== 0 || bdata.size() < 4 * len) begin
            n_err++; $display("FAIL cont_whole_frames_%0d_%0d: got %0d beats want multiple of %0d", len, gap, bdata.size(), len);
        end
        bad = 0;
        for (int i = 0; i < bdata.size(); i++)
            if (buser[i] !== ((i % len) == 0) || blast[i] !== ((i % len) == len - 1) ||
                bdata[i] !== DW'(int'(bdata[0]) + i + (i / len) * gap)) bad++;
        n_vec++;
        if (bad !== 0) begin n_err++; $display("FAIL cont_shape_%0d_%0d: got %0d bad beats want 0", len, gap, bad); end
        frames = bdata.size() / len;
        ahb_read(32'h0C, rd);
        n_vec++;
        if (rd !== {16'(frames), 16'h0002}) begin n_err++; $display("FAIL cont_status_%0d_%0d: got %h want %h", len, gap, rd, {16'(frames), 16'h0002}); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd;
        int bad;
        ahb_write(32'h04, 32'd16);
        clear_log();
        bp_mode = 1'b1;
        ahb_write(32'h00, 32'h1);
        repeat (300) @(posedge hclk); #1;
        bp_mode = 1'b0;
        n_vec++;
        if (bdata.size() !== 16) begin n_err++; $display("FAIL bp_count: got %0d want 16", bdata.size()); end
        bad = 0;
        for (int i = 0; i < bdata.size(); i++)
            if (buser[i] !== (i == 0) || blast[i] !== (i == 15) || bdata[i] !== DW'(int'(bdata[0]) + i)) bad++;
        n_vec++;
        if (bad !== 0) begin n_err++; $display("FAIL bp_shape: got %0d bad beats want 0", bad); end
        ahb_read(32'h0C, rd);
        n_vec++;
        if (rd !== 32'h0001_0002) begin n_err++; $display("FAIL bp_status: got %h want 00010002", rd); end
    endtask

    task automatic test_abort();
        logic [31:0] rd;
        int nlast;
        ahb_write(32'h04, 32'd100);
        ahb_write(32'h0C, 32'h2);
        clear_log();
        ahb_write(32'h00, 32'h1);
        repeat (10) @(posedge hclk); #1;
        ahb_write(32'h00, 32'h4);
        repeat (10) @(posedge hclk); #1;
        n_vec++;
        if (bdata.size() !== 10 + 2 + 1) begin n_err++; $display("FAIL abort_count: got %0d want 13", bdata.size()); end
        nlast = 0;
        for (int i = 0; i < blast.size(); i++) if (blast[i]) nlast++;
        n_vec++;
        if (nlast !== 1 || blast.size() == 0 || blast[blast.size() - 1] !== 1'b1) begin
            n_err++; $display("FAIL abort_tlast: got %0d tlast beats want exactly 1 on final beat", nlast);
        end
        ahb_read(32'h0C, rd);
        n_vec++;
        if (rd !== 32'h0) begin n_err++; $display("FAIL abort_status: got %h want 0", rd); end
        clear_log();
        ahb_write(32'h00, 32'h5);
        repeat (5) @(posedge hclk); #1;
        ahb_read(32'h0C, rd);
        n_vec++;
        if (rd !== 32'h0 || bdata.size() !== 0) begin
            n_err++; $display("FAIL start_abort: got status=%h beats=%0d want 0/0", rd, bdata.size());
        end
    endtask

    task automatic test_irq();
        logic [31:0] rd;
        ahb_write(32'h0C, 32'h2);
        ahb_write(32'h10, 32'h1);
        ahb_write(32'h04, 32'd1);
        ahb_write(32'h00, 32'h1);
        @(negedge hclk);
        n_vec++;
        if ({irq, tvalid_m, tuser_m, tlast_m} !== 4'b0111) begin
            n_err++; $display("FAIL irq_len1_beat: got irq/v/u/l=%b want 0111", {irq, tvalid_m, tuser_m, tlast_m});
        end
        @(negedge hclk);
        n_vec++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL irq_set: got %b want 1", irq); end
        @(posedge hclk); #1;
        ahb_write(32'h0C, 32'h2);
        @(negedge hclk);
        n_vec++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL irq_clear: got %b want 0", irq); end
        ahb_write(32'h04, 32'd2);
        @(posedge hclk); #1;
        ahb_write(32'h00, 32'h1);
        ahb_write(32'h0C, 32'h2);
        @(negedge hclk);
        n_vec++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL irq_set_wins: got %b want 1", irq); end
        @(posedge hclk); #1;
        ahb_read(32'h0C, rd);
        n_vec++;
        if (rd !== 32'h0001_0002) begin n_err++; $display("FAIL set_wins_status: got %h want 00010002", rd); end
        ahb_write(32'h10, 32'h0);
        @(negedge hclk);
        n_vec++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL irq_mask: got %b want 0", irq); end
        @(posedge hclk); #1;
    endtask

    task automatic test_ce_reset();
        logic [31:0] rd;
        int n0, bad;
        ahb_write(32'h04, 32'd20);
        clear_log();
        ahb_write(32'h00, 32'h1);
        repeat (5) @(posedge hclk); #1;
        ce = 1'b0;
        n0 = bdata.size();
        bad = 0;
        repeat (5) begin
            @(negedge hclk);
            if (tvalid_m !== 1'b0 || tready_s !== 1'b0) bad++;
        end
        @(posedge hclk); #1;
        ce = 1'b1;
        n_vec++;
        if (bad !== 0 || n0 !== 5 || bdata.size() !== n0) begin
            n_err++; $display("FAIL ce_freeze: got bad=%0d pre=%0d post=%0d want 0/5/5", bad, n0, bdata.size());
        end
        repeat (30) @(posedge hclk); #1;
        bad = 0;
        for (int i = 0; i < bdata.size(); i++)
            if (buser[i] !== (i == 0) || blast[i] !== (i == 19) || bdata[i] !== DW'(int'(bdata[0]) + i)) bad++;
        n_vec++;
        if (bdata.size() !== 20 || bad !== 0) begin
            n_err++; $display("FAIL ce_frame: got %0d beats %0d bad want 20/0", bdata.size(), bad);
        end
        ahb_write(32'h10, 32'h1);
        ahb_write(32'h04, 32'd50);
        ahb_write(32'h00, 32'h1);
        repeat (10) @(posedge hclk); #3;
        n_vec++;
        if ({irq, tvalid_m} !== 2'b11) begin n_err++; $display("FAIL pre_reset: got irq/valid=%b want 11", {irq, tvalid_m}); end
        hresetn = 1'b0;
        #1;
        n_vec++;
        if ({tvalid_m, tlast_m, tuser_m, irq, hresp_s, hreadyout_s} !== 6'b000001 || hrdata_s !== 32'd0) begin
            n_err++; $display("FAIL async_reset: got v/l/u/irq/resp/rdy=%b rdata=%h want 000001/0",
                              {tvalid_m, tlast_m, tuser_m, irq, hresp_s, hreadyout_s}, hrdata_s);
        end
        repeat (2) @(posedge hclk); #1;
        hresetn = 1'b1;
        ahb_read(32'h04, rd);
        n_vec++;
        if (rd !== 32'd1024) begin n_err++; $display("FAIL reset_flen: got %h want 400", rd); end
        ahb_read(32'h0C, rd);
        n_vec++;
        if (rd !== 32'd0) begin n_err++; $display("FAIL reset_status: got %h want 0", rd); end
        ahb_read(32'h10, rd);
        n_vec++;
        if (rd !== 32'd0) begin n_err++; $display("FAIL reset_irqen: got %h want 0", rd); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_regs();
        test_single_shot(8);
        test_single_shot(1);
        test_single_shot(int'($urandom_range(2, 40)));
        test_continuous(4, 3);
        test_continuous(3, 0);
        test_continuous(int'($urandom_range(1, 6)), int'($urandom_range(0, 4)));
        test_backpressure();
        test_abort();
        test_irq();
        test_ce_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
